pong_game_ctrl: RTL and testbench

PONG_GAME_CTRL -- requirements
Module: pong_game_ctrl

---
 rtl/pong_pkg.sv | 44 ++++
 rtl/pong_game_ctrl_if.sv | 27 ++
 rtl/ball_step.sv | 76 +++++++
 rtl/pong_game_ctrl.sv | 128 ++++++++++++
 tb/tb_pong_game_ctrl.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/pong_pkg.sv
// Shared definitions for the pong game controller: state encodings, ball record,
// serve coordinates and default playfield limits.
package pong_pkg;

    typedef enum logic [2:0] {
        ST_SERVE_L = 3'd0,
        ST_SERVE_R = 3'd1,
        ST_PLAY    = 3'd2,
        ST_POINT   = 3'd3,
        ST_OVER    = 3'd4
    } state_e;

    localparam int X_W     = 10;
    localparam int Y_W     = 9;
    localparam int SCORE_W = 4;

    // Default playfield limits in pixels.
    localparam int DEF_X_LEFT  = 16;
    localparam int DEF_X_RIGHT = 624;
    localparam int DEF_Y_MAX   = 470;

    localparam logic [X_W-1:0] SERVE_L_X = 10'd48;
    localparam logic [X_W-1:0] SERVE_R_X = 10'd575;
    localparam logic [Y_W-1:0] SERVE_Y   = 9'd240;

    // Direction flags are stored as "negative" bits: 1 means -1, 0 means +1.
    typedef struct packed {
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
        logic           dx_neg;
        logic           dy_neg;
    } ball_t;

    // Serving from the left launches down-right; from the right, up-left.
    function automatic ball_t serve_ball(input logic left);
        ball_t b;
        b.x      = left ? SERVE_L_X : SERVE_R_X;
        b.y      = SERVE_Y;
        b.dx_neg = ~left;
        b.dy_neg = ~left;
        return b;
    endfunction

endpackage

// File: rtl/pong_game_ctrl_if.sv
// Player inputs and game-state outputs of the pong controller, bundled as one port.
interface pong_game_ctrl_if;
    import pong_pkg::*;

    logic               frame_tick;
    logic               p1_srv;
    logic               p2_srv;
    logic               p1_hit;
    logic               p2_hit;
    logic [X_W-1:0]     ball_x;
    logic [Y_W-1:0]     ball_y;
    logic [SCORE_W-1:0] p1_score;
    logic [SCORE_W-1:0] p2_score;
    logic [2:0]         state;
    logic               game_over;

    modport master (
        output frame_tick, p1_srv, p2_srv, p1_hit, p2_hit,
        input  ball_x, ball_y, p1_score, p2_score, state, game_over
    );

    modport slave (
        input  frame_tick, p1_srv, p2_srv, p1_hit, p2_hit,
        output ball_x, ball_y, p1_score, p2_score, state, game_over
    );

endinterface

// File: rtl/ball_step.sv
// One frame of ball motion: paddle hits, wall bounces and miss detection,
// computed purely combinationally from the current ball record.
module ball_step
    import pong_pkg::*;
#(
    parameter int B_STEP  = 8,
    parameter int X_LEFT  = DEF_X_LEFT,
    parameter int X_RIGHT = DEF_X_RIGHT,
    parameter int Y_MAX   = DEF_Y_MAX
) (
    input  ball_t cur,
    input  logic  p1_hit,
    input  logic  p2_hit,
    output ball_t nxt,
    output logic  miss
);

    localparam logic [X_W:0]   STEP_X    = (X_W+1)'(B_STEP);
    localparam logic [X_W:0]   LEFT_LIM  = (X_W+1)'(X_LEFT + B_STEP);
    localparam logic [X_W:0]   RIGHT_LIM = (X_W+1)'(X_RIGHT);
    localparam logic [Y_W:0]   STEP_Y    = (Y_W+1)'(B_STEP);
    localparam logic [Y_W:0]   Y_LIM     = (Y_W+1)'(Y_MAX);

    logic         hit;
    logic [X_W:0] x_ext;
    logic [X_W:0] x_sum;
    logic [X_W:0] x_dif;
    logic [Y_W:0] y_ext;
    logic [Y_W:0] y_sum;
    logic [Y_W:0] y_dif;

    // NOTE: every output and temporary gets a default first so no path leaves
    // a value unassigned; otherwise synthesis infers a latch.
    always_comb begin
        nxt   = cur;
        miss  = 1'b0;
        hit   = p1_hit | p2_hit;
        x_ext = {1'b0, cur.x};
        x_sum = x_ext + STEP_X;
        x_dif = x_ext - STEP_X;
        y_ext = {1'b0, cur.y};
        y_sum = y_ext + STEP_Y;
        y_dif = y_ext - STEP_Y;

        // p1 has priority when both paddles report contact.
        if (p1_hit)      nxt.dx_neg = 1'b0;
        else if (p2_hit) nxt.dx_neg = 1'b1;

        // A hit uses the new direction on this same step and cannot miss.
        if (nxt.dx_neg) begin
            miss  = ~hit && (x_ext < LEFT_LIM);
            nxt.x = (x_ext < STEP_X) ? '0 : x_dif[X_W-1:0];
        end else begin
            miss  = ~hit && (x_sum > RIGHT_LIM);
            nxt.x = x_sum[X_W] ? '1 : x_sum[X_W-1:0];
        end
        if (miss) nxt.x = cur.x;

        if (cur.dy_neg) begin
            if (y_ext < STEP_Y) begin
                nxt.y      = '0;
                nxt.dy_neg = 1'b0;
            end else begin
                nxt.y = y_dif[Y_W-1:0];
            end
        end else begin
            if (y_sum > Y_LIM) begin
                nxt.y      = Y_LIM[Y_W-1:0];
                nxt.dy_neg = 1'b1;
            end else begin
                nxt.y = y_sum[Y_W-1:0];
            end
        end
    end

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game controller: serve/play/point/over sequencing, ball position and
// scores, advanced once per video frame.
module pong_game_ctrl
    import pong_pkg::*;
#(
    parameter int B_STEP       = 8,
    parameter int X_LEFT       = DEF_X_LEFT,
    parameter int X_RIGHT      = DEF_X_RIGHT,
    parameter int Y_MAX        = DEF_Y_MAX,
    parameter int WIN_SCORE    = 9,
    parameter int POINT_FRAMES = 60
) (
    input logic             clk,
    input logic             rst_n,
    pong_game_ctrl_if.slave bus
);

    localparam int                 CNT_W    = $clog2(POINT_FRAMES + 1);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(POINT_FRAMES - 1);
    localparam logic [SCORE_W-1:0] WIN      = SCORE_W'(WIN_SCORE);

    state_e             state_q, state_d;
    ball_t              ball_q, ball_d;
    ball_t              step_ball;
    logic               step_miss;
    logic [SCORE_W-1:0] p1_score_q, p1_score_d;
    logic [SCORE_W-1:0] p2_score_q, p2_score_d;
    logic [CNT_W-1:0]   point_cnt_q, point_cnt_d;
    logic               p2_scored_q, p2_scored_d;
    logic               winner;

    ball_step #(
        .B_STEP  (B_STEP),
        .X_LEFT  (X_LEFT),
        .X_RIGHT (X_RIGHT),
        .Y_MAX   (Y_MAX)
    ) u_ball_step (
        .cur    (ball_q),
        .p1_hit (bus.p1_hit),
        .p2_hit (bus.p2_hit),
        .nxt    (step_ball),
        .miss   (step_miss)
    );

    always_comb begin
        state_d     = state_q;
        ball_d      = ball_q;
        p1_score_d  = p1_score_q;
        p2_score_d  = p2_score_q;
        point_cnt_d = point_cnt_q;
        p2_scored_d = p2_scored_q;
        winner      = p2_scored_q ? (p2_score_q >= WIN) : (p1_score_q >= WIN);

        case (state_q)
            // The ball already sits at the serve spot; a press only sets direction.
            ST_SERVE_L: if (bus.p1_srv) begin
                state_d = ST_PLAY;
                ball_d  = serve_ball(1'b1);
            end
            ST_SERVE_R: if (bus.p2_srv) begin
                state_d = ST_PLAY;
                ball_d  = serve_ball(1'b0);
            end
            ST_PLAY: if (bus.frame_tick) begin
                ball_d = step_ball;
                if (step_miss) begin
                    state_d     = ST_POINT;
                    point_cnt_d = '0;
                    p2_scored_d = ball_q.dx_neg;
                    if (ball_q.dx_neg) begin
                        if (p2_score_q < WIN) p2_score_d = p2_score_q + 1'b1;
                    end else begin
                        if (p1_score_q < WIN) p1_score_d = p1_score_q + 1'b1;
                    end
                end
            end
            ST_POINT: if (bus.frame_tick) begin
                if (point_cnt_q == CNT_LAST) begin
                    point_cnt_d = '0;
                    if (winner) begin
                        state_d = ST_OVER;
                    end else begin
                        // The player who conceded serves next.
                        state_d = p2_scored_q ? ST_SERVE_L : ST_SERVE_R;
                        ball_d  = serve_ball(p2_scored_q);
                    end
                end else begin
                    point_cnt_d = point_cnt_q + 1'b1;
                end
            end
            ST_OVER: if (bus.p1_srv || bus.p2_srv) begin
                state_d    = ST_SERVE_R;
                ball_d     = serve_ball(1'b0);
                p1_score_d = '0;
                p2_score_d = '0;
            end
            default: state_d = ST_SERVE_R;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, matching the hardware regardless of order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_SERVE_R;
            ball_q      <= serve_ball(1'b0);
            p1_score_q  <= '0;
            p2_score_q  <= '0;
            point_cnt_q <= '0;
            p2_scored_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ball_q      <= ball_d;
            p1_score_q  <= p1_score_d;
            p2_score_q  <= p2_score_d;
            point_cnt_q <= point_cnt_d;
            p2_scored_q <= p2_scored_d;
        end
    end

    assign bus.ball_x    = ball_q.x;
    assign bus.ball_y    = ball_q.y;
    assign bus.p1_score  = p1_score_q;
    assign bus.p2_score  = p2_score_q;
    assign bus.state     = state_q;
    assign bus.game_over = (state_q == ST_OVER);

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed bench for pong_game_ctrl: full rallies, bounces, misses, a won game
// and asynchronous reset during a point pause.
module tb_pong_game_ctrl;

    localparam logic [2:0] S_SERVE_L = 3'd0;
    localparam logic [2:0] S_SERVE_R = 3'd1;
    localparam logic [2:0] S_PLAY    = 3'd2;
    localparam logic [2:0] S_POINT   = 3'd3;
    localparam logic [2:0] S_OVER    = 3'd4;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    pong_game_ctrl_if bus ();

    pong_game_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input logic h1 = 1'b0, input logic h2 = 1'b0);
        @(negedge clk);
        bus.frame_tick = 1'b1;
        bus.p1_hit     = h1;
        bus.p2_hit     = h2;
        @(negedge clk);
        bus.frame_tick = 1'b0;
        bus.p1_hit     = 1'b0;
        bus.p2_hit     = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic press(input logic s1, input logic s2, input logic with_tick = 1'b0);
        @(negedge clk);
        bus.p1_srv     = s1;
        bus.p2_srv     = s2;
        bus.frame_tick = with_tick;
        @(negedge clk);
        bus.p1_srv     = 1'b0;
        bus.p2_srv     = 1'b0;
        bus.frame_tick = 1'b0;
    endtask

    // Right serve, p1 returns on the first frame, ball leaves the right edge.
    task automatic quick_p1_point();
        press(1'b0, 1'b1);
        tick(1'b1, 1'b0);
        ticks(6);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        n_checks       = 0;
        n_fail         = 0;
        rst_n          = 1'b0;
        bus.frame_tick = 1'b0;
        bus.p1_srv     = 1'b0;
        bus.p2_srv     = 1'b0;
        bus.p1_hit     = 1'b0;
        bus.p2_hit     = 1'b0;
        repeat (3) @(negedge clk);

        check("rst_state", 32'(bus.state), S_SERVE_R);
        check("rst_x", 32'(bus.ball_x), 575);
        check("rst_y", 32'(bus.ball_y), 240);
        check("rst_p1", 32'(bus.p1_score), 0);
        check("rst_p2", 32'(bus.p2_score), 0);
        check("rst_over", 32'(bus.game_over), 0);
        rst_n = 1'b1;

        tick();
        check("serve_hold_x", 32'(bus.ball_x), 575);
        check("serve_hold_state", 32'(bus.state), S_SERVE_R);
        press(1'b1, 1'b0);
        check("serve_r_ignores_p1", 32'(bus.state), S_SERVE_R);
        press(1'b0, 1'b1);
        check("serve_r_to_play", 32'(bus.state), S_PLAY);
        check("serve_no_move", 32'(bus.ball_x), 575);
        tick();
        check("first_step_x", 32'(bus.ball_x), 567);
        check("first_step_y", 32'(bus.ball_y), 232);

        ticks(30);
        check("top_clamp_x", 32'(bus.ball_x), 327);
        check("top_clamp_y", 32'(bus.ball_y), 0);
        tick();
        check("top_bounce_y", 32'(bus.ball_y), 8);
        ticks(37);
        check("near_left_x", 32'(bus.ball_x), 23);
        check("near_left_y", 32'(bus.ball_y), 304);

        tick(1'b1, 1'b0);
        check("p1_hit_x", 32'(bus.ball_x), 31);
        check("p1_hit_y", 32'(bus.ball_y), 312);
        check("p1_hit_no_score", 32'(bus.p2_score), 0);
        check("p1_hit_state", 32'(bus.state), S_PLAY);

        ticks(20);
        check("bottom_clamp_y", 32'(bus.ball_y), 470);
        check("bottom_clamp_x", 32'(bus.ball_x), 191);
        tick();
        check("bottom_bounce_y", 32'(bus.ball_y), 462);
        tick(1'b1, 1'b1);
        check("both_hit_p1_wins", 32'(bus.ball_x), 207);
        ticks(52);
        check("near_right_x", 32'(bus.ball_x), 623);
        check("near_right_state", 32'(bus.state), S_PLAY);
        tick();
        check("right_miss_state", 32'(bus.state), S_POINT);
        check("right_miss_p1", 32'(bus.p1_score), 1);
        check("right_miss_x_held", 32'(bus.ball_x), 623);

        ticks(59);
        check("point_59", 32'(bus.state), S_POINT);
        tick();
        check("point_to_serve_r", 32'(bus.state), S_SERVE_R);
        check("serve_r_load_x", 32'(bus.ball_x), 575);
        check("serve_r_load_y", 32'(bus.ball_y), 240);

        press(1'b0, 1'b1, 1'b1);
        check("srv_tick_state", 32'(bus.state), S_PLAY);
        check("srv_tick_no_move", 32'(bus.ball_x), 575);
        ticks(69);
        check("left_edge_x", 32'(bus.ball_x), 23);
        tick();
        check("left_miss_state", 32'(bus.state), S_POINT);
        check("left_miss_p2", 32'(bus.p2_score), 1);
        check("left_miss_x_held", 32'(bus.ball_x), 23);
        check("left_miss_p1_same", 32'(bus.p1_score), 1);

        ticks(60);
        check("point_to_serve_l", 32'(bus.state), S_SERVE_L);
        check("serve_l_load_x", 32'(bus.ball_x), 48);
        check("serve_l_load_y", 32'(bus.ball_y), 240);
        press(1'b0, 1'b1);
        check("serve_l_ignores_p2", 32'(bus.state), S_SERVE_L);
        press(1'b1, 1'b0);
        check("serve_l_to_play", 32'(bus.state), S_PLAY);
        tick();
        check("serve_l_step_x", 32'(bus.ball_x), 56);
        check("serve_l_step_y", 32'(bus.ball_y), 248);
        ticks(71);
        check("right_limit_x", 32'(bus.ball_x), 624);
        check("right_limit_y", 32'(bus.ball_y), 126);
        check("right_limit_state", 32'(bus.state), S_PLAY);
        tick();
        check("right_limit_miss", 32'(bus.p1_score), 2);
        ticks(60);
        check("back_to_serve_r", 32'(bus.state), S_SERVE_R);

        for (int i = 0; i < 6; i++) begin
            quick_p1_point();
            ticks(60);
        end
        check("p1_eight", 32'(bus.p1_score), 8);
        check("p1_eight_state", 32'(bus.state), S_SERVE_R);

        quick_p1_point();
        check("p1_nine", 32'(bus.p1_score), 9);
        check("p1_nine_state", 32'(bus.state), S_POINT);
        ticks(59);
        check("win_pause_state", 32'(bus.state), S_POINT);
        check("win_pause_over", 32'(bus.game_over), 0);
        tick();
        check("over_state", 32'(bus.state), S_OVER);
        check("over_flag", 32'(bus.game_over), 1);
        check("over_p2", 32'(bus.p2_score), 1);
        tick();
        check("over_hold", 32'(bus.state), S_OVER);
        press(1'b1, 1'b0);
        check("restart_state", 32'(bus.state), S_SERVE_R);
        check("restart_p1", 32'(bus.p1_score), 0);
        check("restart_p2", 32'(bus.p2_score), 0);
        check("restart_over", 32'(bus.game_over), 0);
        check("restart_x", 32'(bus.ball_x), 575);

        quick_p1_point();
        ticks(30);
        check("mid_point_state", 32'(bus.state), S_POINT);
        check("mid_point_cnt", 32'(dut.point_cnt_q), 30);
        check("mid_point_p1", 32'(bus.p1_score), 1);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_state", 32'(bus.state), S_SERVE_R);
        check("async_rst_cnt", 32'(dut.point_cnt_q), 0);
        check("async_rst_x", 32'(bus.ball_x), 575);
        check("async_rst_y", 32'(bus.ball_y), 240);
        check("async_rst_p1", 32'(bus.p1_score), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
